// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock with a registered carry,
// start/busy/done handshake, and result/carry/overflow held in output registers.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int K  = WIDTH / CHUNK;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       op_a;
    logic [WIDTH-1:0]       op_b;
    logic [WIDTH-1:0]       res;
    logic                   carry;
    logic [CW-1:0]          cnt;

    logic [CHUNK:0]         t;
    logic [WIDTH+CHUNK-1:0] res_wide;
    logic [WIDTH-1:0]       res_next;
    logic                   ovf_next;
    logic                   last;

    assign t        = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    // Shifting the concatenation keeps this valid when CHUNK equals WIDTH.
    assign res_wide = {t[CHUNK-1:0], res} >> CHUNK;
    assign res_next = res_wide[WIDTH-1:0];
    // Carry into the top bit recovered from a^b^sum, then XORed with carry out.
    assign ovf_next = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ t[CHUNK-1] ^ t[CHUNK];
    assign last     = (cnt == CW'(K - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    carry <= t[CHUNK];
                    res   <= res_next;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= t[CHUNK];
                        ovf   <= ovf_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: five instances (CHUNK 1,2,4,8,16) checked against a
// scoreboard of expected {sum,cout,ovf} pushed at launch and popped on done.
module tb_serial_adder;

    localparam int W  = 16;
    localparam int NI = 5;
    localparam int NR = 300;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start_v [NI];
    logic         busy_v  [NI];
    logic         done_v  [NI];
    logic [W-1:0] sum_v   [NI];
    logic         cout_v  [NI];
    logic         ovf_v   [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        serial_adder #(.WIDTH(W), .CHUNK(1 << g)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[g]),
            .sub   (sub),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .sum   (sum_v[g]),
            .cout  (cout_v[g]),
            .ovf   (ovf_v[g])
        );
    end

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference: full-width add with two's-complement overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input logic ci);
        logic [W-1:0] bb;
        logic [W:0]   r;
        exp_t         e;
        bb  = s ? ~y : y;
        r   = {1'b0, x} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        e.s = r[W-1:0];
        e.c = r[W];
        e.o = (x[W-1] == bb[W-1]) && (r[W-1] != x[W-1]);
        return e;
    endfunction

    task automatic launch(input int g, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic s, input logic ci);
        a          = x;
        b          = y;
        sub        = s;
        cin        = ci;
        start_v[g] = 1'b1;
        q.push_back(model(x, y, s, ci));
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    // Called at the negedge of RUN cycle c0; returns at the negedge where done is high.
    task automatic await_result(input int g, input int c0, input string name);
        int   k      = W >> g;
        int   c      = c0;
        int   busy_n = 0;
        exp_t e;
        while (done_v[g] !== 1'b1 && c <= k + 4) begin
            if (busy_v[g] === 1'b1) busy_n++;
            @(negedge clk);
            c++;
        end
        n_checks++;
        if (done_v[g] !== 1'b1 || busy_v[g] !== 1'b0 || c != k + 1)
            $display("[TB] FAIL %s timing: done=%b busy=%b at cycle %0d, expected done=1 busy=0 at cycle %0d",
                     name, done_v[g], busy_v[g], c, k + 1);
        else n_pass++;
        n_checks++;
        if (busy_n != k - c0 + 1)
            $display("[TB] FAIL %s busy: high %0d cycles, expected %0d", name, busy_n, k - c0 + 1);
        else n_pass++;
        n_checks++;
        if (q.size() == 0) begin
            $display("[TB] FAIL %s scoreboard: result with no expected entry, got sum=%h", name, sum_v[g]);
        end else begin
            e = q.pop_front();
            if ({sum_v[g], cout_v[g], ovf_v[g]} !== e)
                $display("[TB] FAIL %s result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         name, sum_v[g], cout_v[g], ovf_v[g], e.s, e.c, e.o);
            else n_pass++;
        end
    endtask

    task automatic check_quiet(input int g, input string name);
        @(negedge clk);
        n_checks++;
        if (done_v[g] !== 1'b0 || busy_v[g] !== 1'b0)
            $display("[TB] FAIL %s idle: done=%b busy=%b, expected 0 0", name, done_v[g], busy_v[g]);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        a     = '0;
        b     = '0;
        for (int g = 0; g < NI; g++) start_v[g] = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            n_checks++;
            if ({busy_v[g], done_v[g], sum_v[g], cout_v[g], ovf_v[g]} !== '0)
                $display("[TB] FAIL reset[%0d]: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                         g, busy_v[g], done_v[g], sum_v[g], cout_v[g], ovf_v[g]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        launch(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        await_result(0, 1, "add");
        check_quiet(0, "add_pulse");
    endtask

    task automatic test_wrap();
        launch(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        await_result(0, 1, "wrap_carry");
        @(negedge clk);
        launch(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        await_result(0, 1, "wrap_ovf");
        @(negedge clk);
    endtask

    task automatic test_sub();
        launch(0, 16'h0005, 16'h0007, 1'b1, 1'b1);
        await_result(0, 1, "sub_borrow");
        @(negedge clk);
        launch(0, 16'h8000, 16'h0001, 1'b1, 1'b0);
        await_result(0, 1, "sub_ovf");
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        launch(2, 16'hABCD, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        // Mid-RUN start with different operands must not restart or resample.
        a          = 16'h0000;
        b          = 16'hFFFF;
        sub        = 1'b1;
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        await_result(2, 3, "chunk4");
        launch(2, 16'h0102, 16'h0304, 1'b1, 1'b0);
        n_checks++;
        if (busy_v[2] !== 1'b1 || sum_v[2] !== 16'hBCDF)
            $display("[TB] FAIL b2b hold: busy=%b sum=%h, expected busy=1 sum=bcdf", busy_v[2], sum_v[2]);
        else n_pass++;
        await_result(2, 1, "b2b");
        check_quiet(2, "b2b_pulse");
    endtask

    task automatic test_reset_mid();
        int dn = 0;
        launch(0, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(q.pop_back());
        n_checks++;
        if ({busy_v[0], done_v[0], sum_v[0], cout_v[0], ovf_v[0]} !== '0)
            $display("[TB] FAIL reset_mid: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     busy_v[0], done_v[0], sum_v[0], cout_v[0], ovf_v[0]);
        else n_pass++;
        repeat (20) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) dn++;
        end
        n_checks++;
        if (dn != 0) $display("[TB] FAIL reset_mid done: %0d pulses, expected 0", dn);
        else n_pass++;
        launch(0, 16'hC3A5, 16'h5A5A, 1'b0, 1'b1);
        await_result(0, 1, "after_reset");
        @(negedge clk);
    endtask

    task automatic test_random();
        int gap;
        for (int g = 0; g < NI; g++) begin
            repeat (NR) begin
                gap = $urandom_range(0, 3);
                repeat (gap) @(negedge clk);
                launch(g, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
                await_result(g, 1, "rand");
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
